pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter TRAP_VEC, default 32'h0000_0080, meaning the redirect target on a misaligned jr.
REQ-003 SHALL have parameter TIMEOUT, default 8, meaning the maximum DECIDE cycles before a forced sequential commit.
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port fetch_req, input, 1 bit: the control unit requests an instruction advance.
REQ-007 SHALL have port stall, input, 1 bit: freeze all state.
REQ-008 SHALL have ports seq_valid, input, 1 bit: current instruction is not control flow.
REQ-009 SHALL have ports jump_valid, input, 1 bit, and jump_imm, input, 26 bits: J-type target request.
REQ-010 SHALL have ports branch_valid, input, 1 bit; branch_taken, input, 1 bit; and branch_off, input, 16 bits: conditional branch request.
REQ-011 SHALL have ports jr_valid, input, 1 bit, and jr_addr, input, 32 bits: register-indirect jump request.
REQ-012 SHALL have ports PC, output, 32 bits, and PC_plus4, output, 32 bits: current PC and PC+4.
REQ-013 SHALL have ports pc_valid, output, 1 bit (one-cycle pulse on commit); busy, output, 1 bit (state != IDLE); timeout_err, output, 1 bit (pulse); and misalign_err, output, 1 bit (pulse).

Function
REQ-014 SHALL implement the FSM states IDLE, DECIDE and COMMIT.
REQ-015 In IDLE with fetch_req=1 and stall=0, SHALL go to DECIDE, clear the timeout counter, and latch PC_plus4 = PC + 32'd4 (mod 2^32, wrap silently).
REQ-016 In DECIDE, SHALL pick a source by priority jr > jump > taken-branch > sequential, where seq_valid=1 or (branch_valid=1 and branch_taken=0) means sequential; the chosen target SHALL be latched and the FSM SHALL go to COMMIT.
REQ-017 Targets: jump = {PC_plus4[31:28], jump_imm, 2'b00}; branch = PC_plus4 + (sign-extended branch_off << 2), mod 2^32; jr = jr_addr; sequential = PC_plus4.
REQ-018 When several valids are asserted in the same cycle, SHALL honour only the highest priority and ignore the rest without error.
REQ-019 In DECIDE with no valid asserted, SHALL increment the counter; at counter == TIMEOUT-1 with still no valid, SHALL select sequential, pulse timeout_err, and go to COMMIT.
REQ-020 In COMMIT, SHALL write PC, pulse pc_valid for exactly one cycle, and return to IDLE; latency from the deciding valid to the PC update SHALL be 1 cycle.
REQ-021 With stall=1 in any state, SHALL hold the state, counter, PC and latched target, ignore all inputs, and suppress pc_valid.
REQ-022 In IDLE, fetch_req is level-sampled only when stall=0; the requester SHALL hold it.
REQ-023 fetch_req asserted in DECIDE or COMMIT SHALL be ignored.

Reset
REQ-024 With Reset=0 at the clock edge, SHALL set state=IDLE, PC=RESET_PC, PC_plus4=RESET_PC+4, counter=0, and pc_valid=timeout_err=misalign_err=0.
REQ-025 Reset SHALL take priority over stall and abort DECIDE/COMMIT with no commit.

Configuration
REQ-026 With macro PC_ALIGN_CHECK_EN defined, a selected jr with jr_addr[1:0] != 0 SHALL commit TRAP_VEC and pulse misalign_err in the COMMIT cycle.
REQ-027 Without PC_ALIGN_CHECK_EN, jr_addr SHALL be committed unchanged, and misalign_err SHALL be tied 0.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the source-select encoding (SRC_SEQ, SRC_BR, SRC_J, SRC_JR), and the constant 32'd4.
REQ-029 The J-type target concatenation SHALL be a combinational sub-module jump_target_calc (inputs PC_plus4, jump_imm; output 32-bit target); all else stays in pc_sequencer.

Verification
REQ-030 Reset then fetch_req with seq_valid: PC goes 0 -> 4, with pc_valid high for 1 cycle two edges after fetch_req.
REQ-031 With PC=32'h1000_0000, jump_imm=26'h000_0040: PC becomes 32'h1000_0100.
REQ-032 With PC=32'h0000_0100, branch_taken and branch_off=16'hFFFF: PC becomes 32'h0000_0100; with branch_taken=0, PC becomes 32'h0000_0104.
REQ-033 With jr_valid, jump_valid and branch_valid asserted together, jr_addr=32'h0000_2000: PC becomes 32'h0000_2000; jr_addr=32'h0000_2002 with PC_ALIGN_CHECK_EN: PC becomes 32'h0000_0080 and misalign_err pulses.
REQ-034 No valid for 8 DECIDE cycles: timeout_err pulses and PC advances by 4; stall=1 for 3 cycles mid-DECIDE extends this by exactly 3 cycles.
REQ-035 Reset=0 asserted in DECIDE: next cycle state=IDLE, PC=RESET_PC, and no pc_valid pulse.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared types and constants for the PC sequencer.
//   state_e - sequencer FSM encoding (IDLE, DECIDE, COMMIT)
//   src_e   - next-PC source select (SRC_SEQ, SRC_BR, SRC_J, SRC_JR)
//   PC_INC  - sequential PC increment
package pc_sequencer_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IMM_W = 26;
  localparam int unsigned OFF_W = 16;

  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECIDE = 2'd1,
    COMMIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_SEQ = 2'd0,
    SRC_BR  = 2'd1,
    SRC_J   = 2'd2,
    SRC_JR  = 2'd3
  } src_e;

  // Branch target: word offset, sign-extended, added to PC+4 (wraps mod 2^32).
  function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] pc4,
                                                    input logic [OFF_W-1:0] off);
    return pc4 + {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: request/response bundle between the control unit and the
// PC sequencer.
//   requests : fetch_req, stall, seq_valid, jump_valid/jump_imm,
//              branch_valid/branch_taken/branch_off, jr_valid/jr_addr
//   responses: PC, PC_plus4, pc_valid, busy, timeout_err, misalign_err
//   master = control unit side, slave = sequencer side
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic              fetch_req;
  logic              stall;
  logic              seq_valid;
  logic              jump_valid;
  logic [IMM_W-1:0]  jump_imm;
  logic              branch_valid;
  logic              branch_taken;
  logic [OFF_W-1:0]  branch_off;
  logic              jr_valid;
  logic [XLEN-1:0]   jr_addr;
  logic [XLEN-1:0]   PC;
  logic [XLEN-1:0]   PC_plus4;
  logic              pc_valid;
  logic              busy;
  logic              timeout_err;
  logic              misalign_err;

  modport master (
    output fetch_req, stall, seq_valid, jump_valid, jump_imm,
           branch_valid, branch_taken, branch_off, jr_valid, jr_addr,
    input  PC, PC_plus4, pc_valid, busy, timeout_err, misalign_err
  );

  modport slave (
    input  fetch_req, stall, seq_valid, jump_valid, jump_imm,
           branch_valid, branch_taken, branch_off, jr_valid, jr_addr,
    output PC, PC_plus4, pc_valid, busy, timeout_err, misalign_err
  );

endinterface

// File: rtl/pc_sequencer_jump_target_calc.sv
// jump_target_calc: combinational J-type target.
//   pc_plus4 - latched PC+4 (supplies the upper nibble)
//   jump_imm - 26-bit word index
//   target_c - {pc_plus4[31:28], jump_imm, 2'b00}
module jump_target_calc
  import pc_sequencer_pkg::*;
(
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic [IMM_W-1:0] jump_imm,
  output logic [XLEN-1:0]  target_c
);

  assign target_c = {pc_plus4[31:28], jump_imm, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: IDLE -> DECIDE -> COMMIT next-PC sequencer.
//   CLK   - rising-edge clock
//   Reset - synchronous, active-low
//   bus   - pc_sequencer_if.slave (requests in, PC/status out)
// Source priority in DECIDE: jr > jump > taken branch > sequential. With no
// valid for TIMEOUT DECIDE cycles the sequential target is forced and
// timeout_err pulses. stall freezes everything and suppresses pulses.
// Build option: define PC_ALIGN_CHECK_EN to redirect a misaligned jr to
// TRAP_VEC and pulse misalign_err on its commit; otherwise misalign_err is 0.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0080,
  parameter int unsigned     TIMEOUT  = 8
) (
  input logic           CLK,
  input logic           Reset,
  pc_sequencer_if.slave bus
);

  localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic [XLEN-1:0]   tgt_q, tgt_d;
  logic              pc_valid_q, pc_valid_d;
  logic              tout_q, tout_d;
  logic              busy_q, busy_d;

  src_e              src;
  logic              any_valid;
  logic              jr_bad;
  logic [XLEN-1:0]   jump_tgt_c;
  logic [XLEN-1:0]   sel_tgt;

  jump_target_calc u_jump_target_calc (
    .pc_plus4 (pc4_q),
    .jump_imm (bus.jump_imm),
    .target_c (jump_tgt_c)
  );

  assign any_valid = bus.seq_valid | bus.jump_valid | bus.branch_valid | bus.jr_valid;

`ifdef PC_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  logic mis_err_q, mis_err_d;
  assign jr_bad = bus.jr_valid && (bus.jr_addr[1:0] != 2'b00);
`else
  assign jr_bad = 1'b0;
`endif

  // Highest-priority source; a not-taken branch falls through to sequential.
  always_comb begin
    src = SRC_SEQ;
    if (bus.jr_valid)                             src = SRC_JR;
    else if (bus.jump_valid)                      src = SRC_J;
    else if (bus.branch_valid && bus.branch_taken) src = SRC_BR;
  end

  // Target for the selected source.
  always_comb begin
    case (src)
      SRC_JR:  sel_tgt = jr_bad ? TRAP_VEC : bus.jr_addr;
      SRC_J:   sel_tgt = jump_tgt_c;
      SRC_BR:  sel_tgt = branch_target(pc4_q, bus.branch_off);
      default: sel_tgt = pc4_q;
    endcase
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    pc4_d      = pc4_q;
    tgt_d      = tgt_q;
    pc_valid_d = 1'b0;
    tout_d     = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    mis_d      = mis_q;
    mis_err_d  = 1'b0;
`endif
    if (!bus.stall) begin
      case (state_q)
        IDLE: begin
          if (bus.fetch_req) begin
            state_d = DECIDE;
            cnt_d   = '0;
            pc4_d   = pc_q + PC_INC;
          end
        end
        DECIDE: begin
          if (any_valid) begin
            tgt_d   = sel_tgt;
            state_d = COMMIT;
`ifdef PC_ALIGN_CHECK_EN
            mis_d   = jr_bad;
`endif
          end else if (cnt_q == CNT_LAST) begin
            tgt_d   = pc4_q;
            tout_d  = 1'b1;
            state_d = COMMIT;
`ifdef PC_ALIGN_CHECK_EN
            mis_d   = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        COMMIT: begin
          pc_d       = tgt_q;
          pc_valid_d = 1'b1;
          state_d    = IDLE;
`ifdef PC_ALIGN_CHECK_EN
          mis_err_d  = mis_q;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and status registers.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      cnt_q      <= '0;
      pc_q       <= RESET_PC;
      pc4_q      <= RESET_PC + PC_INC;
      tgt_q      <= RESET_PC;
      pc_valid_q <= 1'b0;
      tout_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      pc4_q      <= pc4_d;
      tgt_q      <= tgt_d;
      pc_valid_q <= pc_valid_d;
      tout_q     <= tout_d;
      busy_q     <= busy_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Misalignment flag carried from DECIDE to the commit pulse.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      mis_q     <= 1'b0;
      mis_err_q <= 1'b0;
    end else begin
      mis_q     <= mis_d;
      mis_err_q <= mis_err_d;
    end
  end
  assign bus.misalign_err = mis_err_q;
`else
  assign bus.misalign_err = 1'b0;
`endif

  assign bus.PC          = pc_q;
  assign bus.PC_plus4    = pc4_q;
  assign bus.pc_valid    = pc_valid_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = tout_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized transactions against a
// transaction-level next-PC model.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0080;
  localparam int          TIMEOUT  = 8;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_pc;

  always #5 CLK = ~CLK;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_PC (RESET_PC),
    .TRAP_VEC (TRAP_VEC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs;
    bus.fetch_req    = 1'b0;
    bus.stall        = 1'b0;
    bus.seq_valid    = 1'b0;
    bus.jump_valid   = 1'b0;
    bus.jump_imm     = '0;
    bus.branch_valid = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_off   = '0;
    bus.jr_valid     = 1'b0;
    bus.jr_addr      = '0;
  endtask

  // Next PC from the priority rules; bit 32 = expected misalign pulse.
  function automatic logic [32:0] model_target(input logic j, b, bt, r,
                                               input logic [25:0] imm,
                                               input logic [15:0] off,
                                               input logic [31:0] ja,
                                               input logic [31:0] pc4);
    int soff;
    if (r) begin
      if (ALIGN && (ja % 4) != 0) return {1'b1, TRAP_VEC};
      return {1'b0, ja};
    end
    if (j) return {1'b0, (pc4 & 32'hF000_0000) + (32'(imm) * 32'd4)};
    if (b && bt) begin
      soff = int'($signed(off));
      return {1'b0, pc4 + 32'(soff * 4)};
    end
    return {1'b0, pc4};
  endfunction

  // One fetch: `empty` no-valid DECIDE cycles, a stall window inside DECIDE,
  // then the request, then `cstall` stall cycles in front of the commit.
  task automatic run_txn(input logic s, j, b, bt, r,
                         input logic [25:0] imm, input logic [15:0] off,
                         input logic [31:0] ja, input int empty,
                         input int st_at, input int st_len, input int cstall);
    logic [31:0] pc4;
    logic [32:0] m;
    logic        tout;
    logic        decided;
    int          nonstall;
    pc4 = exp_pc + 32'd4;
    idle_inputs();
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    check("busy_decide", 32'(bus.busy), 32'd1);
    check("pc_plus4", bus.PC_plus4, pc4);
    check("pc_hold", bus.PC, exp_pc);
    nonstall = 0;
    tout     = 1'b0;
    decided  = 1'b0;
    for (int i = 0; i < 64 && !decided; i++) begin
      if (i >= st_at && i < st_at + st_len) begin
        bus.stall        = 1'b1;
        bus.fetch_req    = 1'($urandom);
        bus.seq_valid    = 1'($urandom);
        bus.jump_valid   = 1'($urandom);
        bus.branch_valid = 1'($urandom);
        bus.branch_taken = 1'($urandom);
        bus.jr_valid     = 1'($urandom);
        bus.jr_addr      = $urandom;
        tick();
        check("stall_no_commit", 32'(bus.timeout_err | bus.pc_valid), 32'd0);
      end else begin
        bus.stall        = 1'b0;
        bus.fetch_req    = 1'($urandom);
        if (nonstall < empty) begin
          bus.seq_valid    = 1'b0;
          bus.jump_valid   = 1'b0;
          bus.branch_valid = 1'b0;
          bus.jr_valid     = 1'b0;
          tick();
          nonstall++;
          if (nonstall == TIMEOUT) begin
            tout    = 1'b1;
            decided = 1'b1;
          end else begin
            check("no_early_timeout", 32'(bus.timeout_err), 32'd0);
          end
        end else begin
          bus.seq_valid    = s;
          bus.jump_valid   = j;
          bus.jump_imm     = imm;
          bus.branch_valid = b;
          bus.branch_taken = bt;
          bus.branch_off   = off;
          bus.jr_valid     = r;
          bus.jr_addr      = ja;
          tick();
          decided = 1'b1;
        end
      end
    end
    if (!decided) check("decide_bound", 32'd0, 32'd1);
    idle_inputs();
    m = tout ? {1'b0, pc4} : model_target(j, b, bt, r, imm, off, ja, pc4);
    check("timeout_err", 32'(bus.timeout_err), 32'(tout));
    check("pc_valid_early", 32'(bus.pc_valid), 32'd0);
    check("busy_commit", 32'(bus.busy), 32'd1);
    for (int k = 0; k < cstall; k++) begin
      bus.stall = 1'b1;
      tick();
      check("cstall_pc", bus.PC, exp_pc);
      check("cstall_valid", 32'(bus.pc_valid | bus.timeout_err), 32'd0);
    end
    bus.stall = 1'b0;
    tick();
    check("pc_valid", 32'(bus.pc_valid), 32'd1);
    check("pc", bus.PC, m[31:0]);
    check("misalign_err", 32'(bus.misalign_err), 32'(m[32]));
    check("busy_idle", 32'(bus.busy), 32'd0);
    exp_pc = m[31:0];
    tick();
    check("pc_valid_pulse", 32'(bus.pc_valid | bus.misalign_err), 32'd0);
  endtask

  initial begin
    logic s, j, b, bt, r;
    idle_inputs();
    Reset = 1'b0;
    tick();
    tick();
    check("rst_pc", bus.PC, RESET_PC);
    check("rst_pc4", bus.PC_plus4, RESET_PC + 32'd4);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_flags", 32'({bus.pc_valid, bus.timeout_err, bus.misalign_err}), 32'd0);
    Reset  = 1'b1;
    exp_pc = RESET_PC;
    tick();

    // Sequential 0 -> 4
    run_txn(1, 0, 0, 0, 0, '0, '0, '0, 0, 99, 0, 0);
    check("dir_seq", bus.PC, 32'h0000_0004);
    // Jump with PC = 1000_0000
    run_txn(0, 0, 0, 0, 1, '0, '0, 32'h1000_0000, 0, 99, 0, 0);
    run_txn(0, 1, 0, 0, 0, 26'h000_0040, '0, '0, 0, 99, 0, 0);
    check("dir_jump", bus.PC, 32'h1000_0100);
    // Branch -1 taken / not taken from 0x100
    run_txn(0, 0, 0, 0, 1, '0, '0, 32'h0000_0100, 0, 99, 0, 0);
    run_txn(0, 0, 1, 1, 0, '0, 16'hFFFF, '0, 0, 99, 0, 0);
    check("dir_br_taken", bus.PC, 32'h0000_0100);
    run_txn(0, 0, 1, 0, 0, '0, 16'hFFFF, '0, 0, 99, 0, 0);
    check("dir_br_not", bus.PC, 32'h0000_0104);
    // All valids together; jr wins
    run_txn(1, 1, 1, 1, 1, 26'h3FF_FFFF, 16'h0010, 32'h0000_2000, 0, 99, 0, 0);
    check("dir_jr", bus.PC, 32'h0000_2000);
    run_txn(1, 1, 1, 1, 1, 26'h3FF_FFFF, 16'h0010, 32'h0000_2002, 0, 99, 0, 0);
    check("dir_jr_mis", bus.PC, ALIGN ? 32'h0000_0080 : 32'h0000_2002);
    // Timeout, then timeout stretched by a 3-cycle stall
    run_txn(0, 0, 0, 0, 0, '0, '0, '0, TIMEOUT, 99, 0, 0);
    run_txn(0, 0, 0, 0, 0, '0, '0, '0, TIMEOUT, 3, 3, 0);
    // Stall in front of the commit
    run_txn(1, 0, 0, 0, 0, '0, '0, '0, 2, 0, 2, 2);

    // fetch_req ignored while stalled in IDLE
    bus.stall     = 1'b1;
    bus.fetch_req = 1'b1;
    tick();
    check("idle_stall_busy", 32'(bus.busy), 32'd0);
    idle_inputs();

    // Reset aborts DECIDE, even with stall and a valid present
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    bus.stall     = 1'b1;
    bus.jr_valid  = 1'b1;
    bus.jr_addr   = 32'h0000_4000;
    Reset         = 1'b0;
    tick();
    check("rst_abort_busy", 32'(bus.busy), 32'd0);
    check("rst_abort_pc", bus.PC, RESET_PC);
    check("rst_abort_valid", 32'(bus.pc_valid), 32'd0);
    Reset = 1'b1;
    idle_inputs();
    tick();
    check("rst_abort_valid2", 32'(bus.pc_valid), 32'd0);
    check("rst_abort_pc2", bus.PC, RESET_PC);
    exp_pc = RESET_PC;

    // Randomized transactions
    for (int t = 0; t < 60; t++) begin
      int empty;
      s  = 1'($urandom);
      j  = 1'($urandom);
      b  = 1'($urandom);
      bt = 1'($urandom);
      r  = 1'($urandom_range(0, 3) == 0);
      empty = ($urandom_range(0, 5) == 0) ? TIMEOUT : int'($urandom_range(0, TIMEOUT - 1));
      if (!(s | j | b | r)) s = 1'b1;
      run_txn(s, j, b, bt, r, 26'($urandom), 16'($urandom), $urandom, empty,
              int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
